// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | Module      : alu_pkg                                              |
// | Description : Opcode type shared by alu_seq and its users.         |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        AND = 3'd3,
        DEC = 3'd4
    } alu_opcode_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq.sv
// +--------------------------------------------------------------------+
// | Module      : alu_seq                                              |
// | Description : Handshaked ALU; single-cycle ADD/SUB/AND/DEC and an  |
// |               iterative shift-add MUL. Define ALU_SEQ_FLAGS_EN to  |
// |               add the zero/carry flag outputs.                     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_seq #(
    parameter int W = 4,
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  alu_pkg::alu_opcode_t opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         result
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                 zero,
    output logic                 carry
`endif
);

    localparam int         c_SW    = $clog2(N);
    localparam int         c_CNT_W = $clog2(W);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_last;

    logic [N-1:0]       r_result;
    logic [2*W-1:0]     r_mcand;
    logic [W-1:0]       r_mplier;
    logic [2*W-1:0]     r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*W-1:0]     w_acc_next;

    logic [W:0]         w_sum;
    logic [c_SW-1:0]    w_shamt;
    logic [N-1:0]       w_res;

    // DEC only looks at the low log2(N) bits of a, padding when a is narrower
    generate
        if (W >= c_SW) begin : g_dec_trunc
            assign w_shamt = a[c_SW-1:0];
        end else begin : g_dec_ext
            assign w_shamt = {{(c_SW-W){1'b0}}, a};
        end
    endgenerate

    assign w_is_mul   = (opcode == alu_pkg::MUL);
    assign w_accept   = in_valid && in_ready;
    assign w_mul_last = (r_cnt == c_CNT_W'(W-1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign result     = r_result;

    always_comb begin
        w_res = '0;
        case (opcode)
            alu_pkg::ADD: w_res = N'(w_sum);
            alu_pkg::SUB: w_res = N'(a) - N'(b);
            alu_pkg::AND: w_res = N'(a & b);
            alu_pkg::DEC: w_res = {{(N-1){1'b0}}, 1'b1} << w_shamt;
            default:      w_res = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            c_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_state_next = w_is_mul ? c_BUSY : c_DONE;
            end
            c_BUSY: begin
                if (w_mul_last) w_state_next = c_DONE;
            end
            c_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (w_accept) w_state_next = w_is_mul ? c_BUSY : c_DONE;
                    else          w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_result <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                if (w_is_mul) begin
                    r_mcand  <= (2*W)'(a);
                    r_mplier <= b;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_result <= w_res;
                end
            end else if (r_state == c_BUSY) begin
                // one multiplier bit per cycle: add shifted multiplicand when set
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CNT_W'(1);
                if (w_mul_last) r_result <= N'(w_acc_next);
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic r_zero;
    logic r_carry;
    logic w_carry;

    always_comb begin
        w_carry = 1'b0;
        case (opcode)
            alu_pkg::ADD: w_carry = w_sum[W];
            alu_pkg::SUB: w_carry = (a < b);
            default:      w_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_zero  <= (w_res == '0);
            r_carry <= w_carry;
        end else if (!w_accept && r_state == c_BUSY && w_mul_last) begin
            r_zero  <= (w_acc_next == '0);
            r_carry <= |w_acc_next[2*W-1:W];
        end
    end

    assign zero  = r_zero;
    assign carry = r_carry;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +--------------------------------------------------------------------+
// | Module      : tb_alu_seq                                           |
// | Description : Self-checking bench for alu_seq with a reference     |
// |               model; flag checks follow ALU_SEQ_FLAGS_EN.          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 4;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    alu_opcode_t opcode;
    logic        out_valid;
    logic        out_ready;
    logic [N-1:0] result;
`ifdef ALU_SEQ_FLAGS_EN
    logic        zero;
    logic        carry;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.W(W), .N(N)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .zero      (zero),
        .carry     (carry)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions
    function automatic int ref_result(input int x, input int y, input int op);
        int r;
        case (op)
            0:       r = x + y;
            1:       r = x - y + (1 << N);
            2:       r = x * y;
            3:       r = x & y;
            4:       r = 1 << (x % N);
            default: r = 0;
        endcase
        return r % (1 << N);
    endfunction

    function automatic int ref_carry(input int x, input int y, input int op);
        case (op)
            0:       return ((x + y) >= (1 << W)) ? 1 : 0;
            1:       return (x < y) ? 1 : 0;
            2:       return ((x * y) >= (1 << W)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int x, input int y, input int op, input int hold,
                           input int exp_res, input int exp_carry, input string tag);
        int lat;
        int busy_ready;
        int exp_lat;
        logic [2:0] op3;
        op3 = op[2:0];
        check_eq({tag, "_in_ready_idle"}, in_ready, 1);
        a         = W'(x);
        b         = W'(y);
        opcode    = alu_opcode_t'(op3);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = alu_opcode_t'(3'(op3 + 3'd1));
        lat        = 1;
        busy_ready = 0;
        while (!out_valid && lat < 4 * W) begin
            if (in_ready) busy_ready++;
            tick();
            lat++;
        end
        exp_lat = (op == 2) ? W + 1 : 1;
        check_eq({tag, "_out_valid"}, out_valid, 1);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_busy_in_ready"}, busy_ready, 0);
        check_eq({tag, "_result"}, result, exp_res);
`ifdef ALU_SEQ_FLAGS_EN
        check_eq({tag, "_zero"}, zero, (exp_res == 0) ? 1 : 0);
        check_eq({tag, "_carry"}, carry, exp_carry);
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, "_hold_result"}, result, exp_res);
            check_eq({tag, "_hold_in_ready"}, in_ready, 0);
            check_eq({tag, "_hold_out_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check_eq({tag, "_retire_in_ready"}, in_ready, 1);
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_retired"}, out_valid, 0);
        if (exp_carry < 0) $display("unexpected carry argument");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int x, y, op, hold;
        logic seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = ADD;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_result", result, 0);
        check_eq("reset_in_ready", in_ready, 1);
`ifdef ALU_SEQ_FLAGS_EN
        check_eq("reset_zero", zero, 0);
        check_eq("reset_carry", carry, 0);
`endif
        reset = 1'b0;
        tick();

        run_txn(15, 1, 0, 0, 'h10, 1, "add_15_1");
        run_txn(3, 5, 1, 1, 'hFE, 1, "sub_3_5");
        run_txn(12, 10, 3, 0, 'h08, 0, "and_c_a");
        run_txn(5, 0, 4, 0, 'h20, 0, "dec_5");
        run_txn(13, 0, 4, 0, 'h20, 0, "dec_13");
        run_txn(15, 15, 2, 2, 'hE1, 1, "mul_15_15");
        run_txn(0, 9, 2, 0, 'h00, 0, "mul_0_9");
        run_txn(6, 3, 7, 0, 'h00, 0, "bad_op");
        run_txn(4, 4, 1, 0, 'h00, 0, "sub_zero");

        // result held for 3 cycles, then retire and accept back-to-back
        a = 4'd9; b = 4'd4; opcode = ADD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("b2b_first_valid", out_valid, 1);
        check_eq("b2b_first_result", result, 'h0D);
        repeat (3) begin
            tick();
            check_eq("b2b_hold_result", result, 'h0D);
            check_eq("b2b_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        a = 4'd1; b = 4'd1; opcode = ADD; in_valid = 1'b1;
        #1;
        check_eq("b2b_in_ready", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("b2b_second_valid", out_valid, 1);
        check_eq("b2b_second_result", result, 'h02);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset on the second BUSY cycle of MUL 7*3
        a = 4'd7; b = 4'd3; opcode = MUL; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_result", result, 0);
        check_eq("abort_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid || result == 8'h15) seen = 1'b1;
        end
        check_eq("abort_no_result", seen, 0);

        // reset wins over a simultaneous accept
        reset = 1'b1;
        a = 4'd2; b = 4'd3; opcode = ADD; in_valid = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_eq("rst_ovr_out_valid", out_valid, 0);
        check_eq("rst_ovr_result", result, 0);
        check_eq("rst_ovr_in_ready", in_ready, 1);

        repeat (300) begin
            x    = $urandom_range(0, (1 << W) - 1);
            y    = $urandom_range(0, (1 << W) - 1);
            op   = $urandom_range(0, 7);
            hold = $urandom_range(0, 2);
            run_txn(x, y, op, hold, ref_result(x, y, op), ref_carry(x, y, op), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
